// File: rtl/pll_pkg.sv
// Shared types and default parameters for the DPLL lock detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_pkg;

    typedef enum logic [1:0] {
        LD_ACQ      = 2'd0,
        LD_LOCKED   = 2'd1,
        LD_DEGRADED = 2'd2
    } lock_state_t;

    localparam int LD_LOCK_CYCLES = 64;
    localparam int LD_MAX_PULSE   = 3;
    localparam int LD_UNLOCK_ERRS = 4;

endpackage

// File: rtl/pll_pulse_qual.sv
// Measures PFD pulse width and flags one error event per over-long pulse.
// Latency: err_evt is combinational from up/down and the registered run length.
// Backpressure: none; scan_en turns pcnt into a shift segment (LSB in, MSB out).
module pll_pulse_qual
    import pll_pkg::*;
#(
    parameter int MAX_PULSE = LD_MAX_PULSE
) (
    input  logic pll_clk,
    input  logic rst_n,
    input  logic up,
    input  logic down,
    input  logic scan_en,
    input  logic scan_in,
    output logic err_evt,
    output logic scan_out
);

    localparam int PW = $clog2(MAX_PULSE + 2);
    localparam logic [PW-1:0] P_ERR = PW'(MAX_PULSE);
    // Parking value one past the error point, so a long pulse fires only once.
    localparam logic [PW-1:0] P_SAT = PW'(MAX_PULSE + 1);

    logic          active;
    logic [PW-1:0] pcnt;

    assign active   = up | down;
    assign err_evt  = active && (pcnt == P_ERR);
    assign scan_out = pcnt[PW-1];

    // Run-length of consecutive active cycles, saturating; shift segment in scan mode.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (scan_en) begin
            pcnt <= PW'({pcnt, scan_in});
        end else if (!active) begin
            pcnt <= '0;
        end else if (pcnt != P_SAT) begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/pll_lock_detect.sv
// Qualifies DPLL lock with hysteresis from PFD up/down pulses; sticky lock-loss flag.
// Latency: locked/lock_lost registered, one pll_clk after the deciding up/down cycle.
// Backpressure: none; scan_en freezes function and shifts the chain. Option: PLL_LOCK_DET_DBG_EN.
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int LOCK_CYCLES = LD_LOCK_CYCLES,
    parameter int MAX_PULSE   = LD_MAX_PULSE,
    parameter int UNLOCK_ERRS = LD_UNLOCK_ERRS
) (
    input  logic pll_clk,
    input  logic rst_n,
    input  logic up,
    input  logic down,
    input  logic clr_sticky,
    input  logic scan_en,
    input  logic scan_in,
    output logic locked,
    output logic lock_lost,
    output logic scan_out
`ifdef PLL_LOCK_DET_DBG_EN
    ,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(UNLOCK_ERRS+1)-1:0]   dbg_ecnt
`endif
);

    localparam int QW = $clog2(LOCK_CYCLES);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(LOCK_CYCLES - 1);
    localparam logic [EW-1:0] E_LAST = EW'(UNLOCK_ERRS - 1);

    lock_state_t   state, state_nxt;
    logic [QW-1:0] qcnt, qcnt_nxt;
    logic [EW-1:0] ecnt, ecnt_nxt;
    logic          lost_set;
    logic          err_evt;
    logic          pq_scan_out;

    // Chain: scan_in -> state -> qcnt -> pcnt -> ecnt -> lock_lost -> locked (-> dbg count).
    pll_pulse_qual #(
        .MAX_PULSE (MAX_PULSE)
    ) u_pulse_qual (
        .pll_clk  (pll_clk),
        .rst_n    (rst_n),
        .up       (up),
        .down     (down),
        .scan_en  (scan_en),
        .scan_in  (qcnt[QW-1]),
        .err_evt  (err_evt),
        .scan_out (pq_scan_out)
    );

    // Next state: clean-window qualification in ACQ/DEGRADED, error counting once locked.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        ecnt_nxt  = ecnt;
        lost_set  = 1'b0;
        case (state)
            LD_ACQ: begin
                if (err_evt) begin
                    qcnt_nxt = '0;
                end else if (qcnt == Q_LAST) begin
                    state_nxt = LD_LOCKED;
                    qcnt_nxt  = '0;
                end else begin
                    qcnt_nxt = qcnt + 1'b1;
                end
            end
            LD_LOCKED: begin
                if (err_evt) begin
                    qcnt_nxt = '0;
                    if (UNLOCK_ERRS == 1) begin
                        state_nxt = LD_ACQ;
                        ecnt_nxt  = '0;
                        lost_set  = 1'b1;
                    end else begin
                        state_nxt = LD_DEGRADED;
                        ecnt_nxt  = EW'(1);
                    end
                end
            end
            LD_DEGRADED: begin
                if (err_evt) begin
                    qcnt_nxt = '0;
                    if (ecnt == E_LAST) begin
                        state_nxt = LD_ACQ;
                        ecnt_nxt  = '0;
                        lost_set  = 1'b1;
                    end else begin
                        ecnt_nxt = ecnt + 1'b1;
                    end
                end else if (qcnt == Q_LAST) begin
                    state_nxt = LD_LOCKED;
                    ecnt_nxt  = '0;
                    qcnt_nxt  = '0;
                end else begin
                    qcnt_nxt = qcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = LD_ACQ;
                qcnt_nxt  = '0;
                ecnt_nxt  = '0;
            end
        endcase
    end

    // State and counter registers; each is a shift segment while scan_en is high.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_ACQ;
            qcnt  <= '0;
            ecnt  <= '0;
        end else if (scan_en) begin
            state <= lock_state_t'({state[0], scan_in});
            qcnt  <= QW'({qcnt, state[1]});
            ecnt  <= EW'({ecnt, pq_scan_out});
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
            ecnt  <= ecnt_nxt;
        end
    end

    // Output flops: locked follows next state directly; lock_lost is sticky, set beats clear.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost <= 1'b0;
            locked    <= 1'b0;
        end else if (scan_en) begin
            lock_lost <= ecnt[EW-1];
            locked    <= lock_lost;
        end else begin
            lock_lost <= lost_set | (lock_lost & ~clr_sticky);
            locked    <= (state_nxt != LD_ACQ);
        end
    end

`ifdef PLL_LOCK_DET_DBG_EN
    logic [15:0] lock_loss_count;

    // Saturating count of lock-loss events; cleared only by rst_n, last in the chain.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_count <= '0;
        end else if (scan_en) begin
            lock_loss_count <= {lock_loss_count[14:0], locked};
        end else if (lost_set && (lock_loss_count != 16'hFFFF)) begin
            lock_loss_count <= lock_loss_count + 16'd1;
        end
    end

    assign dbg_state = state;
    assign dbg_ecnt  = ecnt;
    assign scan_out  = lock_loss_count[15];
`else
    assign scan_out  = locked;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect with a run-length/streak reference model.
// Latency: model outputs compared every negedge outside scan phases.
// Backpressure: n/a.
module tb_pll_lock_detect;

    localparam int LOCK_CYCLES = 64;
    localparam int MAX_PULSE   = 3;
    localparam int UNLOCK_ERRS = 4;
`ifdef PLL_LOCK_DET_DBG_EN
    localparam int CHAIN_LEN = 32;
`else
    localparam int CHAIN_LEN = 16;
`endif

    logic pll_clk;
    logic rst_n;
    logic up, down, clr_sticky, scan_en, scan_in;
    logic locked, lock_lost, scan_out;
`ifdef PLL_LOCK_DET_DBG_EN
    logic [1:0] dbg_state;
    logic [2:0] dbg_ecnt;
`endif

    int checks = 0;
    int errors = 0;
    bit scan_phase = 1'b0;

    // Reference model: integer pulse run, clean streak, error tally since lock.
    int m_run = 0, m_clean = 0, m_errs = 0, m_locked = 0, m_lost = 0;
    bit m_act, m_err, m_set;

    pll_lock_detect #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .MAX_PULSE   (MAX_PULSE),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) dut (
        .pll_clk    (pll_clk),
        .rst_n      (rst_n),
        .up         (up),
        .down       (down),
        .clr_sticky (clr_sticky),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .scan_out   (scan_out)
`ifdef PLL_LOCK_DET_DBG_EN
        ,
        .dbg_state  (dbg_state),
        .dbg_ecnt   (dbg_ecnt)
`endif
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: an error is the cycle a pulse reaches MAX_PULSE+1 active cycles.
    always @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_clean = 0; m_errs = 0; m_locked = 0; m_lost = 0;
        end else if (!scan_en) begin
            m_act = up | down;
            m_err = m_act && (m_run == MAX_PULSE);
            m_run = m_act ? m_run + 1 : 0;
            m_set = 1'b0;
            if (m_locked == 0) begin
                if (m_err) m_clean = 0;
                else begin
                    m_clean++;
                    if (m_clean == LOCK_CYCLES) begin
                        m_locked = 1; m_clean = 0; m_errs = 0;
                    end
                end
            end else if (m_err) begin
                m_errs++; m_clean = 0;
                if (m_errs == UNLOCK_ERRS) begin
                    m_locked = 0; m_errs = 0; m_set = 1'b1;
                end
            end else if (m_errs > 0) begin
                m_clean++;
                if (m_clean == LOCK_CYCLES) begin
                    m_errs = 0; m_clean = 0;
                end
            end
            m_lost = m_set ? 1 : (clr_sticky ? 0 : m_lost);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge pll_clk) begin
        if (!scan_phase) begin
            check("locked", int'(locked), m_locked);
            check("lock_lost", int'(lock_lost), m_lost);
`ifdef PLL_LOCK_DET_DBG_EN
            check("dbg_ecnt", int'(dbg_ecnt), m_errs);
            check("dbg_state", int'(dbg_state), (m_locked == 0) ? 0 : ((m_errs == 0) ? 1 : 2));
`else
            check("scan_out", int'(scan_out), m_locked);
`endif
        end
    end

    task automatic cyc(input logic u, input logic d, input logic c);
        up = u; down = d; clr_sticky = c;
        @(posedge pll_clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // kind: 1=up, 2=down, 3=both; clr_at = index of active cycle carrying clr_sticky.
    task automatic pulse(input int len, input int gap, input int kind, input int clr_at);
        for (int i = 0; i < len; i++) cyc(kind[0], kind[1], i == clr_at);
        idle(gap);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must drop at once.
    task automatic mid_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_locked"}, int'(locked), 0);
        check({name, "_lost"}, int'(lock_lost), 0);
        @(posedge pll_clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        up = 0; down = 0; clr_sticky = 0; scan_en = 0; scan_in = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge pll_clk);
        #1;
        check("reset_locked", int'(locked), 0);
        check("reset_lost", int'(lock_lost), 0);
        check("reset_scan_out", int'(scan_out), 0);
        rst_n = 1'b1;

        // First lock exactly on the 64th edge after release.
        idle(63);
        check("acq_63", int'(locked), 0);
        idle(1);
        check("acq_64", int'(locked), 1);

        // Short pulses (3 cycles, including up+down together) are never errors.
        for (int i = 0; i < 49; i++) pulse(3, 7, 1, -1);
        pulse(3, 7, 3, -1);
        check("short_pulses_locked", int'(locked), 1);
        check("short_pulses_lost", int'(lock_lost), 0);

        // Four long down pulses: degrade on the first, unlock on the fourth.
        pulse(5, 5, 2, -1);
        check("degraded_still_locked", int'(locked), 1);
        pulse(5, 5, 2, -1);
        pulse(5, 5, 2, -1);
        pulse(5, 5, 2, -1);
        check("unlock_locked", int'(locked), 0);
        check("unlock_lost", int'(lock_lost), 1);

        // Re-acquire; sticky flag survives, then clears on request.
        idle(64);
        check("relock", int'(locked), 1);
        check("lost_sticky", int'(lock_lost), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("clr_alone", int'(lock_lost), 0);

        // Two errors then a clean window recovers to full lock with the tally cleared.
        pulse(5, 5, 2, -1);
        pulse(5, 5, 2, -1);
        idle(64);
        pulse(5, 5, 3, -1);
        check("single_err_after_recover", int'(locked), 1);
        pulse(5, 5, 2, -1);
        pulse(5, 5, 1, -1);
        check("three_errs_hold", int'(locked), 1);
        // Fourth error with clr_sticky on the same cycle: set wins.
        pulse(5, 5, 2, 3);
        check("set_beats_clr_locked", int'(locked), 0);
        check("set_beats_clr_lost", int'(lock_lost), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("clr_after_set", int'(lock_lost), 0);

        // Reset while locked with lock_lost set.
        idle(64);
        for (int i = 0; i < 4; i++) pulse(5, 5, 2, -1);
        idle(64);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_lost", int'(lock_lost), 1);
        mid_reset("rst_locked");

        // Reset mid-acquisition restarts the clean window from zero.
        idle(30);
        mid_reset("rst_acq");
        idle(63);
        check("rst_acq_63", int'(locked), 0);
        idle(1);
        check("rst_acq_64", int'(locked), 1);

        // Full-chain rotation mid-acquisition leaves function unchanged.
        mid_reset("rst_pre_scan");
        idle(30);
        scan_phase = 1'b1;
        scan_en = 1'b1;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            scan_in = scan_out;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
        scan_phase = 1'b0;
        idle(33);
        check("frozen_63", int'(locked), 0);
        idle(1);
        check("frozen_64", int'(locked), 1);

        // Walk a single 1 through a zero-flushed chain.
        scan_phase = 1'b1;
        scan_en = 1'b1;
        scan_in = 1'b0;
        idle(CHAIN_LEN);
        scan_in = 1'b1;
        idle(1);
        check("walk_1", int'(scan_out), int'(CHAIN_LEN == 1));
        scan_in = 1'b0;
        for (int k = 2; k <= CHAIN_LEN + 1; k++) begin
            idle(1);
            check($sformatf("walk_%0d", k), int'(scan_out), int'(k == CHAIN_LEN));
        end
        scan_en = 1'b0;
        mid_reset("rst_post_scan");
        scan_phase = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
